// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, op codes and
// the default memory-mapped output register address.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous word RAM with registered read; the array has no reset.
module ram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: wait-stated RAM access, one
// memory-mapped output register, error reporting and a return-to-zero handshake.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 1,
  parameter logic [15:0] IO_ADDR   = DEFAULT_IO_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemR,
  input  logic        MemW,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] readBus,
  output logic        mem_ready,
  output logic        err,
  output logic [15:0] io_out
);

  localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        illegal_q, illegal_d;
  logic        err_pend_q, err_pend_d;
  logic [15:0] rbus_q, rbus_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [15:0] io_q, io_d;

  logic        ram_we;
  logic [15:0] ram_dout;
  logic        is_io;
  logic        in_range;

  assign is_io    = (addr_q == IO_ADDR);
  assign in_range = (addr_q[15:ADDR_W] == '0);

  ram_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(16)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(addr_q[ADDR_W-1:0]),
    .din (wdata_q),
    .dout(ram_dout)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    illegal_d  = illegal_q;
    err_pend_d = err_pend_q;
    rbus_d     = rbus_q;
    io_d       = io_q;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemR || MemW) begin
          addr_d     = addr;
          wdata_d    = wdata;
          op_d       = MemW ? OP_WR : OP_RD;
          cnt_d      = MemW ? WR_CNT : RD_CNT;
          illegal_d  = MemR && MemW;
          err_pend_d = MemR && MemW;
          // A simultaneous read+write skips the access entirely.
          state_d    = (MemR && MemW) ? ACK : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          if (is_io) begin
            if (op_q == OP_WR) io_d = wdata_q;
          end else if (in_range) begin
            ram_we = (op_q == OP_WR);
          end else begin
            err_pend_d = 1'b1;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        rdy_d = 1'b1;
        err_d = err_pend_q;
        // The registered RAM word becomes visible during this state.
        if (op_q == OP_RD && !illegal_q) begin
          if (is_io)         rbus_d = io_q;
          else if (in_range) rbus_d = ram_dout;
          else               rbus_d = 16'h0000;
        end
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!MemR && !MemW) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      cnt_q      <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      illegal_q  <= 1'b0;
      err_pend_q <= 1'b0;
      rbus_q     <= 16'h0000;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      io_q       <= 16'h0000;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      illegal_q  <= illegal_d;
      err_pend_q <= err_pend_d;
      rbus_q     <= rbus_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      io_q       <= io_d;
    end
  end

  assign readBus   = rbus_q;
  assign mem_ready = rdy_q;
  assign err       = err_q;
  assign io_out    = io_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a word-level memory model.
module tb_data_mem_responder;

  localparam int RLAT = 2;
  localparam int WLAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemR = 1'b0;
  logic        MemW = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] readBus;
  logic        mem_ready;
  logic        err;
  logic [15:0] io_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [1024];
  logic        m_vld [1024];
  logic [15:0] m_io = '0;
  logic [15:0] m_rb = '0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W(10), .READ_LAT(RLAT), .WRITE_LAT(WLAT), .IO_ADDR(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .MemR(MemR), .MemW(MemW), .addr(addr),
    .wdata(wdata), .readBus(readBus), .mem_ready(mem_ready), .err(err),
    .io_out(io_out)
  );

  // Issue one request, wait for the ack, then release the request lines.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic [15:0] rb, output logic e,
                        output logic [15:0] io, output logic rdy_after);
    @(negedge clk);
    MemR = r; MemW = w; addr = a; wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!mem_ready && lat < 40);
    rb = readBus; e = err; io = io_out;
    @(negedge clk);
    MemR = 1'b0; MemW = 1'b0; addr = 16'($urandom); wdata = 16'($urandom);
    @(posedge clk); #1;
    rdy_after = mem_ready;
    @(posedge clk);
  endtask

  // Reference: apply a request to the model and return expected results.
  task automatic model(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int lat,
                       output logic [15:0] rb, output logic e, output logic chk_rb);
    logic oor;
    oor = (a != 16'hFFFF) && (a >= 16'd1024);
    chk_rb = 1'b1;
    if (r && w) begin
      lat = 2; e = 1'b1;
    end else if (w) begin
      lat = WLAT + 2; e = oor;
      if (a == 16'hFFFF) m_io = d;
      else if (!oor) begin m_mem[a[9:0]] = d; m_vld[a[9:0]] = 1'b1; end
    end else begin
      lat = RLAT + 2; e = oor;
      if (a == 16'hFFFF) m_rb = m_io;
      else if (oor) m_rb = 16'h0000;
      else begin
        chk_rb = m_vld[a[9:0]];
        m_rb = m_mem[a[9:0]];
      end
    end
    rb = m_rb;
  endtask

  task automatic run_and_check(input string name, input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    int lat, elat;
    logic [15:0] rb, erb, io;
    logic e, ee, chk_rb, rdy_after;
    do_req(r, w, a, d, lat, rb, e, io, rdy_after);
    model(r, w, a, d, elat, erb, ee, chk_rb);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (e !== ee) begin
      errors++; $display("FAIL %s err: got %0b want %0b", name, e, ee);
    end
    checks++;
    if (io !== m_io) begin
      errors++; $display("FAIL %s io_out: got %h want %h", name, io, m_io);
    end
    checks++;
    if (rdy_after !== 1'b0) begin
      errors++; $display("FAIL %s ready pulse width: got %b want 0", name, rdy_after);
    end
    if (chk_rb) begin
      checks++;
      if (rb !== erb) begin
        errors++; $display("FAIL %s readBus: got %h want %h", name, rb, erb);
      end
    end else m_rb = rb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, err, readBus, io_out} !== 34'd0) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b err=%b rb=%h io=%h want all 0",
               mem_ready, err, readBus, io_out);
    end
    @(negedge clk);
    reset = 1'b0;
    m_io = '0; m_rb = '0;
  endtask

  task automatic test_write_read();
    run_and_check("wr_0005", 1'b0, 1'b1, 16'h0005, 16'hA5A5);
    run_and_check("rd_0005", 1'b1, 1'b0, 16'h0005, 16'h0000);
    run_and_check("wr_0000", 1'b0, 1'b1, 16'h0000, 16'h5A5A);
    run_and_check("wr_03ff", 1'b0, 1'b1, 16'h03FF, 16'hC3C3);
    run_and_check("rd_03ff", 1'b1, 1'b0, 16'h03FF, 16'h0000);
  endtask

  task automatic test_io();
    run_and_check("io_wr", 1'b0, 1'b1, 16'hFFFF, 16'h00F3);
    run_and_check("io_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_out_of_range();
    run_and_check("oor_wr", 1'b0, 1'b1, 16'h0400, 16'h1234);
    run_and_check("rd_0000_after_oor", 1'b1, 1'b0, 16'h0000, 16'h0000);
    run_and_check("oor_rd", 1'b1, 1'b0, 16'h0400, 16'h0000);
    run_and_check("oor_rd_fffe", 1'b1, 1'b0, 16'hFFFE, 16'h0000);
  endtask

  task automatic test_illegal();
    run_and_check("illegal", 1'b1, 1'b1, 16'h0000, 16'hDEAD);
    run_and_check("rd_0000_after_ill", 1'b1, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_handshake_hold();
    int pulses, lat;
    @(negedge clk);
    MemR = 1'b1; addr = 16'h0005;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_ready && lat < 40);
    checks++;
    if (lat !== RLAT + 2) begin
      errors++; $display("FAIL hold first latency: got %0d want %0d", lat, RLAT + 2);
    end
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (mem_ready) pulses++; end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL hold extra acks: got %0d want 0", pulses);
    end
    @(negedge clk); MemR = 1'b0;
    @(negedge clk); MemR = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_ready && lat < 40);
    checks++;
    if (lat !== RLAT + 2 || readBus !== m_mem[5]) begin
      errors++;
      $display("FAIL hold reassert: got lat=%0d rb=%h want lat=%0d rb=%h",
               lat, readBus, RLAT + 2, m_mem[5]);
    end
    m_rb = m_mem[5];
    @(negedge clk); MemR = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    run_and_check("pre_wr_0003", 1'b0, 1'b1, 16'h0003, 16'h1111);
    run_and_check("pre_io", 1'b0, 1'b1, 16'hFFFF, 16'h0077);
    @(negedge clk);
    MemW = 1'b1; addr = 16'h0003; wdata = 16'hBEEF;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_ready !== 1'b0 || io_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid outputs: got rdy=%b io=%h want rdy=0 io=0000",
               mem_ready, io_out);
    end
    @(negedge clk);
    reset = 1'b0; MemW = 1'b0;
    m_io = '0; m_rb = '0;
    repeat (2) @(posedge clk);
    run_and_check("rd_0003_after_rst", 1'b1, 1'b0, 16'h0003, 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic r, w;
    int kind;
    for (int i = 0; i < 16; i++)
      run_and_check("rnd_init", 1'b0, 1'b1, 16'(i), 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)      a = 16'($urandom_range(0, 15));
      else if (kind < 8) a = 16'hFFFF;
      else               a = {6'($urandom_range(1, 62)), 10'($urandom)};
      w = $urandom_range(0, 1) == 1;
      r = !w || ($urandom_range(0, 15) == 0);
      run_and_check("rnd", r, w, a, 16'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin m_vld[i] = 1'b0; m_mem[i] = '0; end
    test_reset();
    test_write_read();
    test_io();
    test_out_of_range();
    test_illegal();
    test_handshake_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
